// File: rtl/mips_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM states
// and the default datapath width.
package mips_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;
  localparam logic [2:0] OP_MT    = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the iterative datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide, selected by is_div_i.
module ex_muldiv_step
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                      is_div_i,
  input  logic [2*DATA_WIDTH-1:0]   acc_i,
  input  logic [DATA_WIDTH-1:0]     rem_i,
  input  logic [DATA_WIDTH-1:0]     opb_i,
  output logic [2*DATA_WIDTH-1:0]   acc_o,
  output logic [DATA_WIDTH-1:0]     rem_o
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    // Multiply: acc = {partial sum, multiplier}; add multiplicand on LSB, shift right.
    sum     = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    // Divide: acc[W-1:0] shifts dividend bits out the top and quotient bits in.
    shifted = {rem_i, acc_i[W-1]};
    diff    = shifted - {1'b0, opb_i};
    if (is_div_i) begin
      if (diff[W]) begin
        rem_o = shifted[W-1:0];
        acc_o = {acc_i[2*W-1:W], acc_i[W-2:0], 1'b0};
      end else begin
        rem_o = diff[W-1:0];
        acc_o = {acc_i[2*W-1:W], acc_i[W-2:0], 1'b1};
      end
    end else begin
      rem_o = rem_i;
      acc_o = {sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit with private HI/LO registers and
// a pipeline stall for HI/LO-class instructions while an operation is in flight.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic                  i_sel_lo,
  input  logic [DATA_WIDTH-1:0] i_regA,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_stall
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic [2*W-1:0]   step_acc;
  logic [W-1:0]     step_rem;

  logic             busy;
  logic             accept;
  logic             sgn_op;
  logic             neg_res;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix;
  logic [W-1:0]     rem_fix;

  ex_muldiv_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .is_div_i(is_div_q),
    .acc_i   (acc_q),
    .rem_i   (rem_q),
    .opb_i   (opb_q),
    .acc_o   (step_acc),
    .rem_o   (step_rem)
  );

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign accept = i_valid && !i_flush && is_muldiv_op(i_op);
  assign sgn_op = is_signed_op(i_op);

  // Sign correction applied in FIX; a zero divisor bypasses quotient negation.
  always_comb begin
    neg_res  = sign_a_q ^ sign_b_q;
    prod_fix = neg_res ? (~acc_q + 1'b1) : acc_q;
    if (opb_q == '0) begin
      quo_fix = '1;
    end else begin
      quo_fix = neg_res ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    end
    rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          sign_a_d = sgn_op && i_regA[W-1];
          sign_b_d = sgn_op && i_regB[W-1];
          acc_d    = {{W{1'b0}}, (sgn_op && i_regA[W-1]) ? (~i_regA + 1'b1) : i_regA};
          opb_d    = (sgn_op && i_regB[W-1]) ? (~i_regB + 1'b1) : i_regB;
          rem_d    = '0;
          is_div_d = (i_op == OP_DIV) || (i_op == OP_DIVU);
        end else if (i_valid && (i_op == OP_MT)) begin
          if (i_sel_lo) begin
            lo_d = i_regA;
          end else begin
            hi_d = i_regA;
          end
        end
      end
      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          rem_d = step_rem;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (is_div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            lo_d = prod_fix[W-1:0];
            hi_d = prod_fix[2*W-1:W];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    o_result = '0;
    if (i_valid && !busy) begin
      if (i_op == OP_MFHI) begin
        o_result = hi_q;
      end else if (i_op == OP_MFLO) begin
        o_result = lo_q;
      end
    end
  end

  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_busy  = busy;
  assign o_done  = (state_q == ST_DONE);
  assign o_stall = busy && i_valid && (i_op != OP_NOP);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [2:0]  op;
  logic        sel_lo;
  logic [31:0] rega;
  logic [31:0] regb;
  logic        flush;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_chk  = 0;
  int n_pass = 0;

  ex_muldiv_unit #(
    .DATA_WIDTH(32)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_valid (valid),
    .i_op    (op),
    .i_sel_lo(sel_lo),
    .i_regA  (rega),
    .i_regB  (regb),
    .i_flush (flush),
    .o_result(result),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_busy  (busy),
    .o_done  (done),
    .o_stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Returns {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     t, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = '0;
    case (o)
      OP_MULT:  t = sa * sb;
      OP_MULTU: t = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) begin
          t = {a, 32'hFFFF_FFFF};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          q  = sq;
          r  = sr;
          t  = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          t = {a, 32'hFFFF_FFFF};
        end else begin
          q = ua / ub;
          r = ua % ub;
          t = {r[31:0], q[31:0]};
        end
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  // Issue one mul/div and wait for o_done; checks latency, busy length and HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          lat;
    int          busy_n;
    logic [63:0] e;
    e     = ref_model(o, a, b);
    valid = 1'b1;
    op    = o;
    rega  = a;
    regb  = b;
    tick();
    valid  = 1'b0;
    op     = OP_NOP;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd34);
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
    chk({tag, " hi"}, hi, e[63:32]);
    chk({tag, " lo"}, lo, e[31:0]);
  endtask

  initial begin
    int          stall_bad;
    int          res_bad;
    int          done_seen;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n  = 1'b0;
    valid  = 1'b0;
    op     = OP_NOP;
    sel_lo = 1'b0;
    rega   = '0;
    regb   = '0;
    flush  = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
    chk("mult_7_m3 hi const", hi, 32'hFFFF_FFFF);
    chk("mult_7_m3 lo const", lo, 32'hFFFF_FFEB);
    chk("done busy low", {31'd0, busy}, 32'd0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max lo const", lo, 32'h0000_0001);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_m7_2 lo const", lo, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7 lo const", lo, 32'd14);
    run_op(OP_DIV, 32'd5, 32'd0, "div_by_zero");
    chk("div_by_zero hi const", hi, 32'd5);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf lo const", lo, 32'h8000_0000);
    tick();

    // MFHI/MFLO/MTHI/MTLO while idle.
    valid = 1'b1; op = OP_MT; sel_lo = 1'b0; rega = 32'hCAFE_F00D;
    tick();
    valid = 1'b1; op = OP_MFHI; rega = '0;
    #1;
    chk("mfhi after mthi", result, 32'hCAFE_F00D);
    op = OP_MFLO;
    #1;
    chk("mflo unchanged", result, 32'h8000_0000);
    valid = 1'b0; op = OP_NOP;
    tick();

    // MULT 3x4 followed by an MFLO that must stall until DONE.
    valid = 1'b1; op = OP_MULT; rega = 32'd3; regb = 32'd4;
    tick();
    op        = OP_MFLO;
    stall_bad = 0;
    res_bad   = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (stall !== 1'b1) stall_bad++;
      if (result !== 32'd0) res_bad++;
      tick();
    end
    chk("stall while busy", 32'(stall_bad), 32'd0);
    chk("result zero while busy", 32'(res_bad), 32'd0);
    chk("stall in done", {31'd0, stall}, 32'd0);
    chk("mflo in done", result, 32'd12);
    valid = 1'b0; op = OP_NOP;
    tick();

    // NOP is never stalled.
    valid = 1'b1; op = OP_DIVU; rega = 32'd9; regb = 32'd3;
    tick();
    op = OP_NOP;
    #1;
    chk("nop not stalled", {31'd0, stall}, 32'd0);
    chk("busy during calc", {31'd0, busy}, 32'd1);
    valid = 1'b0;
    for (int i = 0; i < 100 && !done; i++) tick();
    chk("divu_9_3 lo", lo, 32'd3);
    tick();

    // Randomized back-to-back operations.
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 3) rb = 32'd0;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      if (i == 6) begin
        ro = OP_DIV; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end
    tick();

    // Async reset at CALC iteration 10.
    valid = 1'b1; op = OP_MULT; rega = 32'd7; regb = 32'hFFFF_FFFD;
    tick();
    op = OP_MFLO;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset stall", {31'd0, stall}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset result", result, 32'd0);
    valid = 1'b0; op = OP_NOP;
    tick();
    rst_n = 1'b1;
    tick();

    // Flush at iteration 10 after MTLO 0x1234.
    valid = 1'b1; op = OP_MT; sel_lo = 1'b1; rega = 32'h1234;
    tick();
    op = OP_MULT; sel_lo = 1'b0; rega = 32'd3; regb = 32'd4;
    tick();
    valid = 1'b0; op = OP_NOP;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("flush no done", 32'(done_seen), 32'd0);
    chk("flush lo kept", lo, 32'h1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
